instr_sequencer: RTL

//  Drives the processor's 16-bit iin from a small program store, holding each word for a

---
 rtl/instr_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Purpose: feeds processor iin from a small program store, each word held HOLD_CYCLES cycles.
// Latency: first word appears on iin the cycle after start; words follow back-to-back.
// Backpressure: none; halt/step requests take effect only at instruction boundaries (PAUSE halts at once).
//
// Ports:
//   clock, resetn            shared with the processor; resetn async active-low
//   load_en/addr/data        program store write port (honoured only when not busy)
//   start/start_addr         begin issuing at start_addr from IDLE or HALTED
//   step_mode/step           pause after every word; step releases the next one
//   halt_req                 stop at the next instruction boundary
//   iin, pc                  registered instruction word and its store address
//   busy, halted, load_err   status; load_err pulses when a load is dropped
//   instr_count              words completed since start, saturating
module instr_sequencer #(
    parameter int          ADDR_W      = 4,
    parameter int          HOLD_CYCLES = 4,
    parameter logic [15:0] NOP_WORD    = 16'h0000,
    parameter logic [15:0] HALT_WORD   = 16'hFFFF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [15:0]       load_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              step_mode,
    input  logic              step,
    input  logic              halt_req,
    output logic [15:0]       iin,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              load_err,
    output logic [15:0]       instr_count
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, HALTED} state_t;

    localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    state_t            state, state_nxt;
    logic [15:0]       mem [2**ADDR_W];
    logic [HW-1:0]     hold_cnt, hold_nxt;
    logic              halt_pend, pend_nxt;
    logic [15:0]       iin_nxt, cnt_nxt;
    logic [ADDR_W-1:0] pc_nxt, pc_inc, issue_addr;
    logic              halted_nxt, busy_nxt, load_err_nxt;
    logic              issue_en;
    logic [15:0]       fetch;
    logic              can_load;

    assign pc_inc   = pc + ADDR_W'(1);
    assign can_load = (state == IDLE) || (state == HALTED);

    // The only address that can be issued this cycle depends purely on state,
    // so the store read is resolved before the transition logic uses it.
    assign issue_addr = (state == RUN)   ? pc_inc :
                        (state == PAUSE) ? pc     : start_addr;
    assign fetch      = mem[issue_addr];

    // Program store is intentionally not reset.
    always_ff @(posedge clock) begin
        if (load_en && can_load) begin
            mem[load_addr] <= load_data;
        end
    end

    always_comb begin
        state_nxt    = state;
        iin_nxt      = iin;
        pc_nxt       = pc;
        hold_nxt     = hold_cnt;
        pend_nxt     = halt_pend;
        halted_nxt   = halted;
        cnt_nxt      = instr_count;
        issue_en     = 1'b0;
        load_err_nxt = load_en && !can_load;

        case (state)
            IDLE, HALTED: begin
                if (start) begin
                    cnt_nxt    = 16'd0;
                    halted_nxt = 1'b0;
                    issue_en   = 1'b1;
                end
            end
            RUN: begin
                hold_nxt = hold_cnt + HW'(1);
                if (halt_req) begin
                    pend_nxt = 1'b1;
                end
                if (hold_cnt == HOLD_LAST) begin
                    if (instr_count != 16'hFFFF) begin
                        cnt_nxt = instr_count + 16'd1;
                    end
                    // A request arriving on the boundary cycle itself is honoured too.
                    if (halt_pend || halt_req) begin
                        state_nxt = IDLE;
                        iin_nxt   = NOP_WORD;
                        pc_nxt    = pc_inc;
                        pend_nxt  = 1'b0;
                    end else if (step_mode) begin
                        state_nxt = PAUSE;
                        iin_nxt   = NOP_WORD;
                        pc_nxt    = pc_inc;
                    end else begin
                        issue_en = 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (halt_req) begin
                    state_nxt = IDLE;
                    iin_nxt   = NOP_WORD;
                    pend_nxt  = 1'b0;
                end else if (step) begin
                    issue_en = 1'b1;
                end
            end
            default: ;
        endcase

        // HALT_WORD is never placed on iin; it just parks the sequencer.
        if (issue_en) begin
            pc_nxt = issue_addr;
            if (fetch == HALT_WORD) begin
                iin_nxt    = NOP_WORD;
                state_nxt  = HALTED;
                halted_nxt = 1'b1;
            end else begin
                iin_nxt   = fetch;
                hold_nxt  = '0;
                state_nxt = RUN;
            end
        end

        busy_nxt = (state_nxt == RUN) || (state_nxt == PAUSE);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            iin         <= NOP_WORD;
            pc          <= '0;
            hold_cnt    <= '0;
            halt_pend   <= 1'b0;
            busy        <= 1'b0;
            halted      <= 1'b0;
            load_err    <= 1'b0;
            instr_count <= 16'd0;
        end else begin
            state       <= state_nxt;
            iin         <= iin_nxt;
            pc          <= pc_nxt;
            hold_cnt    <= hold_nxt;
            halt_pend   <= pend_nxt;
            busy        <= busy_nxt;
            halted      <= halted_nxt;
            load_err    <= load_err_nxt;
            instr_count <= cnt_nxt;
        end
    end

endmodule
